// File: rtl/util_spi_master_if.sv
// Bundle of the request/response handshake and the tri-stated SPI master bus
// driven by util_spi_master.
interface util_spi_master_if #(
  parameter int SLAVE_NUM  = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int SEL_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;

  logic [DATA_WIDTH-1:0] s_tx_data;
  logic [SEL_W-1:0]      s_tx_sel;
  logic                  s_tx_valid;
  logic                  s_tx_ready;
  logic [DATA_WIDTH-1:0] m_rx_data;
  logic                  m_rx_valid;
  logic                  busy;
  logic                  spi_clk_o;
  logic                  spi_clk_t;
  logic                  spi_mosi_o;
  logic                  spi_mosi_t;
  logic                  spi_miso_i;
  logic [SLAVE_NUM-1:0]  spi_cs_o;
  logic                  spi_cs_t;

  modport master (
    input  s_tx_data, s_tx_sel, s_tx_valid, spi_miso_i,
    output s_tx_ready, m_rx_data, m_rx_valid, busy,
           spi_clk_o, spi_clk_t, spi_mosi_o, spi_mosi_t, spi_cs_o, spi_cs_t
  );

  modport slave (
    output s_tx_data, s_tx_sel, s_tx_valid, spi_miso_i,
    input  s_tx_ready, m_rx_data, m_rx_valid, busy,
           spi_clk_o, spi_clk_t, spi_mosi_o, spi_mosi_t, spi_cs_o, spi_cs_t
  );
endinterface

// File: rtl/util_spi_master.sv
// Single-word SPI master: one word per request, MSB first, divided SCLK with
// compile-time CPOL/CPHA; every bus output comes straight from a flop.
module util_spi_master #(
  parameter int   SLAVE_NUM  = 4,
  parameter int   DATA_WIDTH = 8,
  parameter int   CLK_DIV    = 4,
  parameter logic CPOL       = 1'b0,
  parameter logic CPHA       = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  util_spi_master_if.master bus
);
  localparam int SEL_W  = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;
  localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_TC    = CNT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [EDGE_W-1:0]     edge_q, edge_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  mosi_t_q, mosi_t_d;
  logic [SLAVE_NUM-1:0]  cs_q, cs_d;

  logic                  tc;
  logic [EDGE_W-1:0]     edge_nxt;
  logic                  lead;

  assign tc       = (cnt_q == CNT_TC);
  assign edge_nxt = edge_q + EDGE_W'(1);
  assign lead     = edge_nxt[0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    ready_d    = ready_q;
    busy_d     = busy_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    mosi_t_d   = mosi_t_q;
    cs_d       = cs_q;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.s_tx_valid && ready_q) begin
          state_d  = SETUP;
          cnt_d    = '0;
          edge_d   = '0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          mosi_t_d = 1'b1;
          // CPHA=0 puts the MSB out now, so the shifter starts one bit ahead
          if (CPHA) begin
            tx_d   = bus.s_tx_data;
            mosi_d = 1'b0;
          end else begin
            tx_d   = bus.s_tx_data << 1;
            mosi_d = bus.s_tx_data[DATA_WIDTH-1];
          end
          for (int i = 0; i < SLAVE_NUM; i++) cs_d[i] = (bus.s_tx_sel != SEL_W'(i));
        end
      end
      SETUP: begin
        cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
        if (tc) state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
        if (tc) begin
          sclk_d = ~sclk_q;
          edge_d = edge_nxt;
          // sample on leading edges for CPHA=0, trailing edges for CPHA=1
          if (lead ^ CPHA) begin
            rx_d = {rx_q[DATA_WIDTH-2:0], bus.spi_miso_i};
          end else if (edge_nxt != EDGE_LAST) begin
            mosi_d = tx_q[DATA_WIDTH-1];
            tx_d   = tx_q << 1;
          end
          if (edge_nxt == EDGE_LAST) state_d = HOLD;
        end
      end
      HOLD: begin
        cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
        if (tc) begin
          state_d    = GAP;
          cs_d       = '1;
          mosi_t_d   = 1'b0;
          mosi_d     = 1'b0;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_q;
        end
      end
      GAP: begin
        cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
        if (tc) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      sclk_q     <= CPOL;
      mosi_q     <= 1'b0;
      mosi_t_q   <= 1'b0;
      cs_q       <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      mosi_t_q   <= mosi_t_d;
      cs_q       <= cs_d;
    end
  end

  assign bus.s_tx_ready = ready_q;
  assign bus.m_rx_data  = rx_data_q;
  assign bus.m_rx_valid = rx_valid_q;
  assign bus.busy       = busy_q;
  assign bus.spi_clk_o  = sclk_q;
  assign bus.spi_clk_t  = 1'b1;
  assign bus.spi_mosi_o = mosi_q;
  assign bus.spi_mosi_t = mosi_t_q;
  assign bus.spi_cs_o   = cs_q;
  assign bus.spi_cs_t   = 1'b1;
endmodule

// File: tb/tb_util_spi_master.sv
// Three engines side by side: default loopback, CPOL=1/CPHA=1 with 3 selects and
// a slave shifting out its own word, and CLK_DIV=1 loopback.
module tb_util_spi_master;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0]       tx_valid = '0;
  logic [2:0][7:0]  tx_data  = '0;
  logic [2:0][1:0]  tx_sel   = '0;
  logic [7:0]       sword    = '0;

  wire [2:0]        ready_m, busy_m, rxv_m, sclk_m, mosi_m, mosit_m, clkt_m, cst_m;
  wire [2:0][7:0]   rxd_m, cap_m;
  wire [2:0][3:0]   cs_m;
  wire [2:0][31:0]  ecnt_m;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int   CD  = (g == 2) ? 1 : 4;
    localparam int   SN  = (g == 1) ? 3 : 4;
    localparam logic POL = (g == 1);
    localparam logic PHA = (g == 1);

    util_spi_master_if #(.SLAVE_NUM(SN), .DATA_WIDTH(8)) bus ();
    util_spi_master #(.SLAVE_NUM(SN), .DATA_WIDTH(8), .CLK_DIV(CD), .CPOL(POL), .CPHA(PHA))
      u_dut (.clk(clk), .rst(rst), .bus(bus));

    logic [3:0] cs_w;
    logic       sp     = POL;
    logic       miso_s = 1'b0;
    int         ecnt   = 0;
    int         fe     = 0;
    logic [7:0] cap    = '0;

    always_comb begin
      cs_w = 4'hF;
      cs_w[SN-1:0] = bus.spi_cs_o;
    end

    assign bus.s_tx_valid = tx_valid[g];
    assign bus.s_tx_data  = tx_data[g];
    assign bus.s_tx_sel   = tx_sel[g];
    if (PHA) begin : g_slv
      assign bus.spi_miso_i = miso_s;
    end else begin : g_lb
      assign bus.spi_miso_i = bus.spi_mosi_o;
    end

    assign ready_m[g] = bus.s_tx_ready;
    assign busy_m[g]  = bus.busy;
    assign rxv_m[g]   = bus.m_rx_valid;
    assign rxd_m[g]   = bus.m_rx_data;
    assign sclk_m[g]  = bus.spi_clk_o;
    assign mosi_m[g]  = bus.spi_mosi_o;
    assign mosit_m[g] = bus.spi_mosi_t;
    assign clkt_m[g]  = bus.spi_clk_t;
    assign cst_m[g]   = bus.spi_cs_t;
    assign cs_m[g]    = cs_w;
    assign ecnt_m[g]  = ecnt;
    assign cap_m[g]   = cap;

    // Slave side: count SCLK edges in the frame, capture MOSI on the sampling
    // edge, and change MISO on leading edges.
    always @(negedge clk) begin
      if (bus.spi_clk_o !== sp) begin
        ecnt++;
        fe++;
        if (fe[0] == !PHA) cap = {cap[6:0], bus.spi_mosi_o};
        if (fe[0] && fe <= 16) miso_s = sword[7 - (fe - 1) / 2];
      end
      sp = bus.spi_clk_o;
      if (!bus.busy) fe = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One transfer on engine g; m is the word the far end returns on MISO.
  task automatic xfer(input int g, input logic [7:0] d, input logic [1:0] sel,
                      input logic [7:0] m, input bit keep, output int t0);
    int cd, lat, k, rxk, rdk, csok, pulses, e0;
    logic [7:0] rxw;
    logic [3:0] cse, csat;
    logic pol;
    bit acc;
    cd  = (g == 2) ? 1 : 4;
    pol = (g == 1);
    lat = 1 + 2 * cd + 16 * cd;
    cse = 4'hF;
    if (!(g == 1 && sel == 2'd3)) cse[sel] = 1'b0;
    sword = m;
    tx_data[g] = d;
    tx_sel[g]  = sel;
    tx_valid[g] = 1'b1;
    k = 0;
    do begin
      acc = ready_m[g];
      @(posedge clk); #1;
      k++;
    end while (!acc && k < 200);
    t0 = cyc - 1;
    chk("accept", acc, 1);
    tx_valid[g] = keep;
    if (keep) begin
      tx_data[g] = ~d;
      tx_sel[g]  = sel + 2'd1;
    end
    if (!acc) return;
    chk("t1_ready", ready_m[g], 0);
    chk("t1_busy", busy_m[g], 1);
    chk("t1_mosi_t", mosit_m[g], 1);
    chk("t1_sclk_idle", sclk_m[g], pol);
    if (g != 1) chk("t1_mosi_msb", mosi_m[g], d[7]);
    e0 = int'(ecnt_m[g]);
    rxk = 0; rdk = 0; csok = 0; pulses = 0; rxw = '0; csat = '0;
    for (k = 1; k < 400 && rdk == 0; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k < lat && cs_m[g] == cse) csok++;
      if (rxv_m[g]) begin
        pulses++;
        if (rxk == 0) begin rxk = k; rxw = rxd_m[g]; csat = cs_m[g]; end
      end
      if (k > 1 && ready_m[g]) rdk = k;
    end
    chk("rx_lat", rxk, lat);
    chk("ready_lat", rdk, lat + cd);
    chk("rx_pulses", pulses, 1);
    chk("rx_data", rxw, m);
    chk("cs_frame", csok, lat - 1);
    chk("cs_gap", csat, 4'hF);
    chk("sclk_edges", int'(ecnt_m[g]) - e0, 16);
    chk("mosi_word", cap_m[g], d);
    chk("sclk_after", sclk_m[g], pol);
    chk("busy_after", busy_m[g], 0);
    chk("rx_held", rxd_m[g], m);
  endtask

  initial begin
    int t0, t1, e0, p, w;
    logic [7:0] d, m;
    logic [1:0] s;
    bit acc;

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_ready", ready_m[g], 0);
      chk("rst_busy", busy_m[g], 0);
      chk("rst_rxv", rxv_m[g], 0);
      chk("rst_rxd", rxd_m[g], 0);
      chk("rst_cs", cs_m[g], 4'hF);
      chk("rst_sclk", sclk_m[g], (g == 1));
      chk("rst_mosi", mosi_m[g], 0);
      chk("rst_mosi_t", mosit_m[g], 0);
      chk("rst_clk_t", clkt_m[g], 1);
      chk("rst_cs_t", cst_m[g], 1);
    end
    rst = 1'b0;
    for (int g = 0; g < 3; g++) chk("rel_ready_pre", ready_m[g], 0);
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) chk("rel_ready_post", ready_m[g], 1);

    xfer(0, 8'hA5, 2'd2, 8'hA5, 1'b0, t0);
    xfer(1, 8'hFF, 2'd0, 8'h3C, 1'b0, t0);

    // valid held high across the frame with a decoy word, then back-to-back
    xfer(0, 8'h01, 2'd2, 8'h01, 1'b1, t0);
    xfer(0, 8'h80, 2'd1, 8'h80, 1'b0, t1);
    chk("b2b_accept", t1 - t0, 77);

    // reset in the middle of a frame
    tx_data[0] = 8'h96; tx_sel[0] = 2'd1; tx_valid[0] = 1'b1;
    w = 0;
    do begin
      acc = ready_m[0];
      @(posedge clk); #1;
      w++;
    end while (!acc && w < 200);
    tx_valid[0] = 1'b0;
    e0 = int'(ecnt_m[0]);
    w = 0;
    while (int'(ecnt_m[0]) - e0 < 5 && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    chk("mid_5_edges", (int'(ecnt_m[0]) - e0 >= 5), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cs", cs_m[0], 4'hF);
    chk("mid_rst_sclk", sclk_m[0], 0);
    chk("mid_rst_mosi_t", mosit_m[0], 0);
    chk("mid_rst_ready", ready_m[0], 0);
    chk("mid_rst_busy", busy_m[0], 0);
    p = rxv_m[0];
    repeat (2) begin @(posedge clk); #1; p += rxv_m[0]; end
    rst = 1'b0;
    chk("mid_rel_ready_pre", ready_m[0], 0);
    @(posedge clk); #1;
    chk("mid_rel_ready_post", ready_m[0], 1);
    repeat (80) begin @(posedge clk); #1; p += rxv_m[0]; end
    chk("mid_no_rx", p, 0);
    xfer(0, 8'h5A, 2'd0, 8'h5A, 1'b0, t0);

    xfer(1, 8'h99, 2'd3, 8'h42, 1'b0, t0);
    xfer(2, 8'hC3, 2'd3, 8'hC3, 1'b0, t0);

    for (int g = 0; g < 3; g++) begin
      for (int r = 0; r < 6; r++) begin
        d = 8'($urandom);
        s = 2'($urandom_range(0, 3));
        m = (g == 1) ? 8'($urandom) : d;
        xfer(g, d, s, m, (r < 5) ? 1'($urandom_range(0, 1)) : 1'b0, t0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
